// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and March C- element table for ram_bist
//
// Purpose: FSM state and phase enums, the element count, and the per-element
//          table (direction, read expectation, write value, write enable).
// Ports:   none (package).
package ram_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   typedef enum logic {
      PH_RD,
      PH_WR
   } phase_t;

   localparam int          NUM_ELEM  = 6;
   localparam logic [2:0]  LAST_ELEM = 3'(NUM_ELEM - 1);

   // Backgrounds are single bits replicated across the data width:
   // 0 selects B0 (all zeros), 1 selects B1 (all ones).
   typedef struct packed {
      logic desc;     // 1: walk 2^AW-1 down to 0
      logic has_rd;   // element starts each address with an RD cycle
      logic rd_bg;    // expected background on read
      logic wr_en;    // WR cycle actually writes
      logic wr_bg;    // background written
   } elem_cfg_t;

   function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
      elem_cfg_t cfg;
      cfg = '0;
      case (elem)
         3'd0: begin cfg.wr_en = 1'b1; cfg.wr_bg = 1'b0; end
         3'd1: begin cfg.has_rd = 1'b1; cfg.rd_bg = 1'b0; cfg.wr_en = 1'b1; cfg.wr_bg = 1'b1; end
         3'd2: begin cfg.has_rd = 1'b1; cfg.rd_bg = 1'b1; cfg.wr_en = 1'b1; cfg.wr_bg = 1'b0; end
         3'd3: begin cfg.desc = 1'b1; cfg.has_rd = 1'b1; cfg.rd_bg = 1'b0; cfg.wr_en = 1'b1; cfg.wr_bg = 1'b1; end
         3'd4: begin cfg.desc = 1'b1; cfg.has_rd = 1'b1; cfg.rd_bg = 1'b1; cfg.wr_en = 1'b1; cfg.wr_bg = 1'b0; end
         3'd5: begin cfg.has_rd = 1'b1; cfg.rd_bg = 1'b0; end
         default: cfg = '0;
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - RAM port bundle between the BIST engine and one RAM port
//
// Purpose: groups the single-port RAM access signals.
// Signals: ram_addr (AW), ram_data (DW), ram_we (1) driven by the initiator;
//          ram_q (DW) registered read data returned by the RAM.
// Modports: master (BIST engine side), slave (RAM side).
interface ram_bist_if #(
   parameter int AW = 6,
   parameter int DW = 8
) ();
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_we;
   logic [DW-1:0] ram_q;

   modport master (
      output ram_addr,
      output ram_data,
      output ram_we,
      input  ram_q
   );

   modport slave (
      input  ram_addr,
      input  ram_data,
      input  ram_we,
      output ram_q
   );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// rtl/ram_bist_addr_gen.sv - AW-bit up/down address counter for march sequencing
//
// Purpose: address counter with clear-to-zero, load-to-end (all ones) and a
//          terminal flag that depends on the current count direction.
// Ports:   clk, rst    clock, synchronous active-high reset
//          clr         load 0 (start of an ascending element)
//          load_end    load 2^AW-1 (start of a descending element)
//          en          step one address in the direction given by down
//          down        1: count down, 0: count up
//          addr        current address
//          term        last address of the walk in the current direction
module ram_bist_addr_gen #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load_end,
   input  logic          en,
   input  logic          down,
   output logic [AW-1:0] addr,
   output logic          term
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         addr <= '0;
      end else if (load_end) begin
         addr <= '1;
      end else if (en) begin
         addr <= down ? addr - AW'(1) : addr + AW'(1);
      end
   end

   assign term = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - March C- built-in self-test engine for one RAM port
//
// Purpose: runs March C- (W0 up; R0W1 up; R1W0 up; R0W1 down; R1W0 down;
//          R0 up) on one port of a RAM with registered read data and
//          reports pass/fail. busy is the port-mux select.
// Ports:   clk, rst     clock, synchronous active-high reset
//          start        begin a test (accepted in IDLE or DONE)
//          ram          ram_bist_if.master: ram_addr, ram_data, ram_we, ram_q
//          busy         test running
//          done         test finished, held until next accepted start
//          fail         sticky mismatch flag
//          fail_addr    address of first mismatch
//          fail_elem    march element of first mismatch
//          fail_data    ram_q observed at first mismatch
// Config:  RAM_BIST_DIAG_EN enables first-mismatch capture on fail_addr,
//          fail_elem and fail_data; without it those ports read 0.
module ram_bist
   import ram_bist_pkg::*;
#(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   ram_bist_if.master    ram,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic [2:0]    fail_elem,
   output logic [DW-1:0] fail_data
);

   state_t     state_q, state_n;
   phase_t     phase_q, phase_n;
   logic [2:0] elem_q, elem_n;
   logic       fail_q, fail_n;

   elem_cfg_t  cfg;
   elem_cfg_t  cfg_nx;

   logic          cnt_clr;
   logic          cnt_load_end;
   logic          cnt_en;
   logic [AW-1:0] cnt;
   logic          cnt_term;

   logic run;
   logic wr_ph;
   logic mismatch;
   logic accept;

   assign cfg    = elem_cfg(elem_q);
   assign cfg_nx = elem_cfg(elem_q + 3'd1);

   ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load_end (cnt_load_end),
      .en       (cnt_en),
      .down     (cfg.desc),
      .addr     (cnt),
      .term     (cnt_term)
   );

   assign run   = (state_q == ST_RUN);
   assign wr_ph = run && (phase_q == PH_WR);

   // ram_q was latched by the RAM on the RD edge and is held through the
   // following write, so it is stable for the whole WR/compare cycle.
   assign mismatch = wr_ph && cfg.has_rd && (ram.ram_q != {DW{cfg.rd_bg}});

   assign ram.ram_we   = wr_ph && cfg.wr_en;
   assign ram.ram_addr = run ? cnt : '0;
   assign ram.ram_data = (wr_ph && cfg.wr_en) ? {DW{cfg.wr_bg}} : '0;

   assign busy = run;
   assign done = (state_q == ST_DONE);
   assign fail = fail_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         phase_q <= PH_WR;
         elem_q  <= 3'd0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         phase_q <= phase_n;
         elem_q  <= elem_n;
         fail_q  <= fail_n;
      end
   end

   always_comb begin
      state_n      = state_q;
      phase_n      = phase_q;
      elem_n       = elem_q;
      fail_n       = fail_q;
      cnt_clr      = 1'b0;
      cnt_load_end = 1'b0;
      cnt_en       = 1'b0;
      accept       = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = ST_RUN;
               phase_n = PH_WR;     // element 0 is write-only
               elem_n  = 3'd0;
               fail_n  = 1'b0;
               cnt_clr = 1'b1;
            end
         end

         ST_RUN: begin
            if (mismatch) begin
               fail_n = 1'b1;
            end
            if (phase_q == PH_RD) begin
               phase_n = PH_WR;
            end else if (cnt_term) begin
               if (elem_q == LAST_ELEM) begin
                  state_n = ST_DONE;
               end else begin
                  // Next element starts on the very next cycle; the counter
                  // is preloaded to that element's first address.
                  elem_n  = elem_q + 3'd1;
                  phase_n = cfg_nx.has_rd ? PH_RD : PH_WR;
                  if (cfg_nx.desc) begin
                     cnt_load_end = 1'b1;
                  end else begin
                     cnt_clr = 1'b1;
                  end
               end
            end else begin
               cnt_en  = 1'b1;
               phase_n = cfg.has_rd ? PH_RD : PH_WR;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

`ifdef RAM_BIST_DIAG_EN
   logic [AW-1:0] fail_addr_q;
   logic [2:0]    fail_elem_q;
   logic [DW-1:0] fail_data_q;

   // Only the first mismatch of a run is kept: capture is gated by fail_q,
   // which is still low on the edge that first sets it.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
         fail_data_q <= '0;
      end else if (mismatch && !fail_q) begin
         fail_addr_q <= cnt;
         fail_elem_q <= elem_q;
         fail_data_q <= ram.ram_q;
      end
   end

   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign fail_data = fail_data_q;
`else
   assign fail_addr = '0;
   assign fail_elem = 3'd0;
   assign fail_data = '0;
`endif

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - self-checking bench for ram_bist with a dual-port RAM model
module tb_ram_bist;

   localparam int AW = 6;
   localparam int DW = 8;
   localparam int RUN_CYC = 705;

   typedef struct {
      logic          fail;
      logic [AW-1:0] addr;
      logic [2:0]    elem;
      logic [DW-1:0] data;
      int            done_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_data;

   ram_bist_if #(.AW(AW), .DW(DW)) rif ();

   ram_bist #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ram       (rif),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_data (fail_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int t0 = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Dual-port RAM: port A from the engine, port B used to plant faults.
   // Read data is registered and held while port A writes.
   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] q = '0;
   logic          b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_data = '0;

   initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;

   always @(posedge clk) begin
      if (rif.ram_we) mem[rif.ram_addr] <= rif.ram_data;
      else            q <= mem[rif.ram_addr];
      if (b_we)       mem[b_addr] <= b_data;
   end
   assign rif.ram_q = q;

   int            inj_cyc = 0;
   logic [AW-1:0] inj_addr = '0;
   logic [DW-1:0] inj_data = '0;
   always @(negedge clk) begin
      b_we   = (inj_cyc != 0) && (cyc - t0 == inj_cyc);
      b_addr = inj_addr;
      b_data = inj_data;
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
   endtask

   // Reference: walks the March C- algorithm cycle by cycle from the element
   // list, with one optional port-B write landing on the edge ending cycle fw.
   function automatic exp_t model(input int fw, input int fa, input logic [DW-1:0] fd);
      int   desc [6] = '{0, 0, 0, 1, 1, 0};
      int   rdv  [6] = '{-1, 0, 1, 0, 1, 0};
      int   wrv  [6] = '{0, 1, 0, 1, 0, -1};
      logic [DW-1:0] m [1<<AW];
      logic [DW-1:0] rq;
      exp_t e;
      int   k, off, a;
      bit   rd;
      for (int i = 0; i < (1<<AW); i++) m[i] = '0;
      rq = '0;
      e.fail = 0; e.addr = '0; e.elem = '0; e.data = '0; e.done_cyc = 0;
      for (int c = 1; c < RUN_CYC; c++) begin
         if (c <= 64) begin
            k = 0; a = c - 1; rd = 0;
         end else begin
            k   = (c - 65) / 128 + 1;
            off = (c - 65) % 128;
            a   = desc[k] != 0 ? 63 - off / 2 : off / 2;
            rd  = (off % 2) == 0;
         end
         if (rd) begin
            rq = m[a];
         end else begin
            if (k > 0 && rq != {DW{rdv[k] == 1}}) begin
               if (!e.fail) begin
                  e.addr = AW'(a); e.elem = 3'(k); e.data = rq;
               end
               e.fail = 1;
            end
            if (wrv[k] >= 0) m[a] = {DW{wrv[k] == 1}};
         end
         if (c == fw) m[fa] = fd;
      end
`ifndef RAM_BIST_DIAG_EN
      e.addr = '0; e.elem = '0; e.data = '0;
`endif
      return e;
   endfunction

   exp_t sb [$];
   exp_t mon_e;
   logic done_prev = 1'b0;
   bit   trace_en = 0;

   // Monitor: pops one expectation per rising done and checks the result.
   always @(negedge clk) begin
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
               mon_e = sb.pop_front();
               chk("done_cycle", cyc, mon_e.done_cyc);
               chk("busy_at_done", busy, 0);
               chk("fail", fail, mon_e.fail);
               chk("fail_addr", fail_addr, mon_e.addr);
               chk("fail_elem", fail_elem, mon_e.elem);
               chk("fail_data", fail_data, mon_e.data);
            end
         end
         done_prev = done;
         if (trace_en) begin
            case (cyc - t0)
               1: begin
                  chk("trace1_addr", rif.ram_addr, 0);
                  chk("trace1_we", rif.ram_we, 1);
                  chk("trace1_data", rif.ram_data, 8'h00);
                  chk("trace1_busy", busy, 1);
               end
               321: begin
                  chk("trace321_addr", rif.ram_addr, 63);
                  chk("trace321_we", rif.ram_we, 0);
               end
               322: begin
                  chk("trace322_addr", rif.ram_addr, 63);
                  chk("trace322_we", rif.ram_we, 1);
                  chk("trace322_data", rif.ram_data, 8'hFF);
               end
               704: chk("trace704_busy", busy, 1);
               default: ;
            endcase
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_we"}, rif.ram_we, 0);
      chk({tag, "_addr"}, rif.ram_addr, 0);
      chk({tag, "_data"}, rif.ram_data, 0);
      chk({tag, "_faddr"}, fail_addr, 0);
      chk({tag, "_felem"}, fail_elem, 0);
      chk({tag, "_fdata"}, fail_data, 0);
   endtask

   task automatic wait_drain(input string tag);
      int guard = 0;
      while (sb.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL %s_timeout: got %0d results pending expected 0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_test(input int fw, input int fa, input logic [DW-1:0] fd, input bit trace);
      exp_t e;
      e = model(fw, fa, fd);
      @(negedge clk);
      inj_cyc  = fw;
      inj_addr = AW'(fa);
      inj_data = fd;
      trace_en = trace;
      start    = 1'b1;
      t0       = cyc;
      e.done_cyc = t0 + RUN_CYC;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_drain("run");
      trace_en = 0;
      inj_cyc  = 0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      int   guard;

      repeat (3) @(negedge clk);
      chk_reset("por");
      rst = 1'b0;
      @(negedge clk);

      // Clean run with port trace.
      run_test(0, 0, '0, 1);

      // Planted fault during element 1.
      run_test(70, 10, 8'h5A, 0);

      // Reset mid-test, then a clean rerun.
      e = model(0, 0, '0);
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      e.done_cyc = t0 + RUN_CYC;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (cyc - t0 < 300 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk("abort_busy_before_rst", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      chk_reset("midrst");
      rst = 1'b0;
      run_test(0, 0, '0, 0);

      // Randomized single-fault runs.
      for (int r = 0; r < 4; r++) begin
         run_test(int'($urandom_range(1, RUN_CYC - 1)), int'($urandom_range(0, 63)),
                  DW'($urandom_range(0, 255)), 0);
      end

      // start held high: no restart while busy, restart on the DONE edge.
      e = model(0, 0, '0);
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      e.done_cyc = t0 + RUN_CYC;
      sb.push_back(e);
      e.done_cyc = t0 + 2 * RUN_CYC;
      sb.push_back(e);
      guard = 0;
      while (cyc - t0 < RUN_CYC + 1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk("held_busy", busy, 1);
      chk("held_done", done, 0);
      chk("held_fail", fail, 0);
      chk("held_pending", sb.size(), 1);
      start = 1'b0;
      wait_drain("held");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
